spi_xfer_ctrl: RTL and testbench



---
 rtl/spi_xfer_ctrl.sv | 147 ++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_ctrl.sv
// SPI byte-transfer sequencer (CPHA=0, programmable SCK half-period) driven by ctrl-code commands.
// Optional LSB-first wire order when SPI_XFER_LSBF_EN is defined (adds CFG_LSBF input).
module spi_xfer_ctrl #(
  parameter int DIV_W = 4,
  parameter int NSS   = 2
) (
  input  logic             CLK,
  input  logic             nRESET,
  input  logic             CMD_VALID,
  input  logic [1:0]       CMD_OP,
  input  logic [7:0]       CMD_DATA,
  output logic             CMD_READY,
  input  logic [DIV_W-1:0] CFG_DIV,
  input  logic             CFG_CPOL,
`ifdef SPI_XFER_LSBF_EN
  input  logic             CFG_LSBF,
`endif
  input  logic             MISO,
  output logic             MOSI,
  output logic             SCK,
  output logic [NSS-1:0]   nSS,
  output logic [7:0]       RX_DATA,
  output logic             BUSY,
  output logic             DONE,
  output logic             OVR
);

  typedef enum logic [2:0] {IDLE, SETUP, LEAD, TRAIL, FIN} state_t;

  localparam logic [1:0] OP_XFER = 2'b01;
  localparam logic [1:0] OP_SEL  = 2'b10;
  localparam logic [1:0] OP_DSEL = 2'b11;

  state_t           state, nxt;
  logic [7:0]       tx_q, rx_q;
  logic [DIV_W-1:0] div_q, half_q;
  logic [2:0]       bit_q;
  logic             cpol_q, lsbf_q, lsbf_in;
  logic             half_zero, bit_zero;

`ifdef SPI_XFER_LSBF_EN
  assign lsbf_in = CFG_LSBF;
`else
  assign lsbf_in = 1'b0;
`endif

  assign half_zero = (half_q == '0);
  assign bit_zero  = (bit_q == 3'd0);

  always_ff @(posedge CLK) begin
    if (!nRESET) state <= IDLE;
    else         state <= nxt;
  end

  always_comb begin
    nxt       = state;
    CMD_READY = 1'b0;
    BUSY      = 1'b1;
    DONE      = 1'b0;
    case (state)
      IDLE: begin
        CMD_READY = 1'b1;
        BUSY      = 1'b0;
        if (CMD_VALID && CMD_OP == OP_XFER) nxt = SETUP;
      end
      SETUP: nxt = LEAD;
      LEAD:  if (half_zero) nxt = TRAIL;
      TRAIL: if (half_zero) nxt = bit_zero ? FIN : LEAD;
      FIN: begin
        DONE = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // TX and RX use separate shifters so the unsent TX bits are never overwritten by MISO samples.
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      SCK     <= 1'b0;
      MOSI    <= 1'b0;
      nSS     <= '1;
      RX_DATA <= 8'h00;
      OVR     <= 1'b0;
      tx_q    <= 8'h00;
      rx_q    <= 8'h00;
      div_q   <= '0;
      half_q  <= '0;
      bit_q   <= 3'd0;
      cpol_q  <= 1'b0;
      lsbf_q  <= 1'b0;
    end else begin
      if (CMD_VALID && !CMD_READY) OVR <= 1'b1;
      else if (CMD_VALID)          OVR <= 1'b0;

      case (state)
        IDLE: begin
          SCK <= CFG_CPOL;
          if (CMD_VALID) begin
            case (CMD_OP)
              OP_SEL:  nSS <= CMD_DATA[NSS-1:0];
              OP_DSEL: nSS <= '1;
              OP_XFER: begin
                tx_q   <= CMD_DATA;
                div_q  <= CFG_DIV;
                cpol_q <= CFG_CPOL;
                lsbf_q <= lsbf_in;
              end
              default: ;
            endcase
          end
        end
        SETUP: begin
          MOSI   <= lsbf_q ? tx_q[0] : tx_q[7];
          SCK    <= cpol_q;
          bit_q  <= 3'd7;
          half_q <= div_q;
        end
        LEAD: begin
          if (half_zero) begin
            SCK    <= ~cpol_q;
            rx_q   <= lsbf_q ? {MISO, rx_q[7:1]} : {rx_q[6:0], MISO};
            half_q <= div_q;
          end else begin
            half_q <= half_q - 1'b1;
          end
        end
        TRAIL: begin
          if (half_zero) begin
            SCK    <= cpol_q;
            half_q <= div_q;
            if (!bit_zero) begin
              tx_q  <= lsbf_q ? {1'b0, tx_q[7:1]} : {tx_q[6:0], 1'b0};
              MOSI  <= lsbf_q ? tx_q[1] : tx_q[6];
              bit_q <= bit_q - 1'b1;
            end
          end else begin
            half_q <= half_q - 1'b1;
          end
        end
        FIN:     RX_DATA <= rx_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed table-driven bench for spi_xfer_ctrl plus hand sequences for select, overrun and reset abort.
module tb_spi_xfer_ctrl;
  logic       CLK = 1'b0;
  logic       nRESET;
  logic       CMD_VALID;
  logic [1:0] CMD_OP;
  logic [7:0] CMD_DATA;
  logic       CMD_READY;
  logic [3:0] CFG_DIV;
  logic       CFG_CPOL;
  logic       CFG_LSBF;
  logic       MISO, MOSI, SCK;
  logic [1:0] nSS;
  logic [7:0] RX_DATA;
  logic       BUSY, DONE, OVR;
  logic       loop_en, miso_const;

  int tests = 0;
  int fails = 0;

  assign MISO = loop_en ? MOSI : miso_const;

  always #5 CLK = ~CLK;

  spi_xfer_ctrl #(.DIV_W(4), .NSS(2)) dut (
    .CLK(CLK), .nRESET(nRESET), .CMD_VALID(CMD_VALID), .CMD_OP(CMD_OP),
    .CMD_DATA(CMD_DATA), .CMD_READY(CMD_READY), .CFG_DIV(CFG_DIV), .CFG_CPOL(CFG_CPOL),
`ifdef SPI_XFER_LSBF_EN
    .CFG_LSBF(CFG_LSBF),
`endif
    .MISO(MISO), .MOSI(MOSI), .SCK(SCK), .nSS(nSS), .RX_DATA(RX_DATA),
    .BUSY(BUSY), .DONE(DONE), .OVR(OVR)
  );

  typedef struct {
    logic [7:0] data;
    logic [3:0] div;
    logic       cpol;
    logic       lsbf;
    logic       loop;
    logic       miso1;
    int         ovr_cyc;
    logic [7:0] exp_mosi;
    logic [7:0] exp_rx;
    int         exp_cycles;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [7:0] d);
    CMD_VALID = 1'b1; CMD_OP = op; CMD_DATA = d;
    tick();
    CMD_VALID = 1'b0; CMD_OP = 2'b00;
  endtask

  task automatic run_xfer(input vec_t v);
    int n, done_n, done_cnt, ready_n, tog, last_t;
    logic [7:0] mosi_b;
    logic sck_p, halves_ok, nss_ok;
    CFG_DIV = v.div; CFG_CPOL = v.cpol; CFG_LSBF = v.lsbf;
    loop_en = v.loop; miso_const = v.miso1;
    tick();
    chk("idle_sck", SCK, v.cpol);
    cmd(2'b01, v.data);
    // Config scrambled while busy: must not affect the transfer in flight.
    CFG_DIV = ~v.div; CFG_CPOL = ~v.cpol; CFG_LSBF = ~v.lsbf;
    chk("busy_after_accept", {BUSY, CMD_READY}, 2'b10);
    n = 0; done_n = -1; done_cnt = 0; ready_n = -1; tog = 0; last_t = 0;
    mosi_b = 8'h00; sck_p = SCK; halves_ok = 1'b1; nss_ok = 1'b1;
    while (ready_n < 0 && n < 400) begin
      tick();
      n++;
      if (v.ovr_cyc == n) begin
        CMD_VALID = 1'b1; CMD_OP = 2'b01; CMD_DATA = 8'h00;
      end else if (v.ovr_cyc + 1 == n) begin
        CMD_VALID = 1'b0; CMD_OP = 2'b00;
      end
      if (SCK != sck_p) begin
        if (SCK != v.cpol) mosi_b = {mosi_b[6:0], MOSI};
        if (tog > 0 && n - last_t != int'(v.div) + 1) halves_ok = 1'b0;
        tog++; last_t = n;
      end
      sck_p = SCK;
      if (DONE) begin
        done_cnt++;
        if (done_n < 0) done_n = n;
      end
      if (nSS != 2'b10) nss_ok = 1'b0;
      if (CMD_READY) ready_n = n;
    end
    chk("ready_cycle", ready_n, v.exp_cycles);
    chk("done_cycle", done_n, v.exp_cycles - 1);
    chk("done_width", done_cnt, 1);
    chk("rx_data", RX_DATA, v.exp_rx);
    chk("mosi_bits", mosi_b, v.exp_mosi);
    chk("sck_toggles", tog, 16);
    chk("sck_half_period", halves_ok, 1'b1);
    chk("sck_end_level", SCK, v.cpol);
    chk("nss_held", nss_ok, 1'b1);
    if (v.ovr_cyc != 0) begin
      chk("ovr_set", OVR, 1'b1);
      cmd(2'b00, 8'h00);
      chk("ovr_clear", OVR, 1'b0);
    end
  endtask

  initial begin
    nRESET = 1'b0; CMD_VALID = 1'b0; CMD_OP = 2'b00; CMD_DATA = 8'h00;
    CFG_DIV = 4'd0; CFG_CPOL = 1'b0; CFG_LSBF = 1'b0; loop_en = 1'b0; miso_const = 1'b0;

    //            data   div   cpol lsbf loop m1 ovr  mosi   rx     cycles
    vecs.push_back('{8'hA5, 4'd0,  0, 0, 1, 0, 0,  8'hA5, 8'hA5, 18});
    vecs.push_back('{8'h3C, 4'd3,  1, 0, 0, 1, 0,  8'h3C, 8'hFF, 66});
    vecs.push_back('{8'h5A, 4'd1,  0, 0, 0, 0, 20, 8'h5A, 8'h00, 34});
    vecs.push_back('{8'h81, 4'd15, 0, 0, 1, 0, 0,  8'h81, 8'h81, 258});
    vecs.push_back('{8'hC3, 4'd2,  1, 0, 1, 0, 0,  8'hC3, 8'hC3, 50});
`ifdef SPI_XFER_LSBF_EN
    vecs.push_back('{8'h01, 4'd0,  0, 1, 1, 0, 0,  8'h80, 8'h01, 18});
    vecs.push_back('{8'h6E, 4'd1,  1, 1, 0, 1, 0,  8'h76, 8'hFF, 34});
`endif

    tick(); tick();
    chk("rst_outputs", {SCK, MOSI, nSS, BUSY, DONE, OVR}, {1'b0, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0});
    chk("rst_rx", RX_DATA, 8'h00);
    nRESET = 1'b1;
    tick();
    chk("ready_after_rst", CMD_READY, 1'b1);

    cmd(2'b10, 8'hFE);
    chk("select", {nSS, DONE, CMD_READY}, {2'b10, 1'b0, 1'b1});

    foreach (vecs[i]) run_xfer(vecs[i]);

    // Reset during a transfer aborts at the next edge with no DONE.
    CFG_DIV = 4'd0; CFG_CPOL = 1'b1; loop_en = 1'b0; miso_const = 1'b1;
    tick();
    cmd(2'b01, 8'hFF);
    for (int k = 0; k < 6; k++) tick();
    chk("mid_xfer_busy", BUSY, 1'b1);
    nRESET = 1'b0;
    tick();
    chk("abort_pins", {SCK, MOSI, nSS, BUSY, DONE}, {1'b0, 1'b0, 2'b11, 1'b0, 1'b0});
    chk("abort_rx", RX_DATA, 8'h00);
    tick();
    nRESET = 1'b1;
    tick();
    chk("abort_no_done", {DONE, CMD_READY}, 2'b01);

    cmd(2'b10, 8'h01);
    chk("select2", nSS, 2'b01);
    cmd(2'b11, 8'h00);
    chk("deselect", nSS, 2'b11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
